// File: rtl/video_pkg.sv
// Shared encodings and constants for the raster frame source.
package video_pkg;

  localparam int unsigned RGB_W       = 24;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_HBLANK = 3'd2,
    ST_VSYNC  = 3'd3,
    ST_VBLANK = 3'd4
  } state_e;

  // Pixel payload: blue in the top byte, red in the bottom byte.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  // Bar colours, index 0 (white) on the left through index 7 (black).
  localparam logic [7:0][RGB_W-1:0] BAR_RGB = {
    24'h000000,  // 7 black
    24'hFF0000,  // 6 blue
    24'h0000FF,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'hFFFF00,  // 2 cyan
    24'h00FFFF,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational test-pattern lookup: active coordinate and mode to one RGB pixel.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int unsigned SIZE_X     = 64,
  parameter int unsigned CHECK_LOG2 = 3,
  parameter int unsigned XW         = 7,
  parameter int unsigned YW         = 8
) (
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  mode_e            mode,
  input  logic [RGB_W-1:0] solid_rgb,
  output logic [RGB_W-1:0] pixel_c
);

  localparam int unsigned BAR_MSB = $clog2(SIZE_X) - 1;

  logic [31:0] x32;
  logic [31:0] y32;
  logic [2:0]  bar_idx;
  rgb_t        grad_rgb;
  logic        unused_bits;

  assign x32         = 32'(x);
  assign y32         = 32'(y);
  assign bar_idx     = x32[BAR_MSB -: 3];
  assign unused_bits = ^{x32, y32};

  always_comb begin
    grad_rgb = '{b: x32[7:0], g: x32[7:0], r: x32[7:0]};
    pixel_c  = '0;
    case (mode)
      MODE_SOLID: pixel_c = solid_rgb;
      MODE_GRAD:  pixel_c = grad_rgb;
      MODE_BARS:  pixel_c = BAR_RGB[bar_idx];
      MODE_CHECK: pixel_c = (x32[CHECK_LOG2] ^ y32[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      default:    pixel_c = '0;
    endcase
  end

endmodule

// File: rtl/video_frame_gen.sv
// Raster frame source: line/frame timing FSM with registered pixel, sync and status outputs.
module video_frame_gen
  import video_pkg::*;
#(
  parameter int unsigned SIZE_X     = 64,
  parameter int unsigned SIZE_Y     = 128,
  parameter int unsigned H_SIZE     = 83,
  parameter int unsigned V_BLANK    = 4,
  parameter int unsigned CHECK_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [RGB_W-1:0]       solid_rgb,
  output logic [RGB_W-1:0]       pixel_out,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned LEN_X = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam int unsigned LEN_Y = ((SIZE_Y + V_BLANK) > 1) ? $clog2(SIZE_Y + V_BLANK) : 1;

  localparam logic [LEN_X-1:0] X_LAST    = LEN_X'(SIZE_X - 1);
  localparam logic [LEN_X-1:0] X_BLANK0  = LEN_X'(SIZE_X);
  localparam logic [LEN_X-1:0] H_LAST    = LEN_X'(H_SIZE - 1);
  localparam logic [LEN_Y-1:0] Y_LAST    = LEN_Y'(SIZE_Y - 1);
  localparam logic [LEN_Y-1:0] Y_VB0     = LEN_Y'(SIZE_Y);
  localparam logic [LEN_Y-1:0] Y_VB_LAST = LEN_Y'(SIZE_Y + V_BLANK - 1);
  localparam bit HAS_HBLANK = (H_SIZE > SIZE_X);
  localparam bit HAS_VBLANK = (V_BLANK > 0);

  state_e           state_q, state_d;
  logic [LEN_X-1:0] h_q, h_d;
  logic [LEN_Y-1:0] y_q, y_d;
  mode_e            mode_q, mode_d;
  logic             cont_q, cont_d;
  logic             stop_q, stop_d;
  logic             frame_start;
  logic             stop_eff;

  logic                   de_d;
  logic                   hsync_d;
  logic                   vsync_d;
  logic                   busy_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  logic [RGB_W-1:0]       pat_c;
  logic [RGB_W-1:0]       pixel_d;

  // Pattern is evaluated on the coordinate that will be on the outputs next cycle.
  video_pattern_pixel #(
    .SIZE_X     (SIZE_X),
    .CHECK_LOG2 (CHECK_LOG2),
    .XW         (LEN_X),
    .YW         (LEN_Y)
  ) u_pattern (
    .x         (h_d),
    .y         (y_d),
    .mode      (mode_d),
    .solid_rgb (solid_rgb),
    .pixel_c   (pat_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      y_q       <= '0;
      mode_q    <= MODE_SOLID;
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      pixel_out <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      cont_q    <= cont_d;
      stop_q    <= stop_d;
      pixel_out <= pixel_d;
      de_out    <= de_d;
      hsync_out <= hsync_d;
      vsync_out <= vsync_d;
      busy      <= busy_d;
      frame_cnt <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    y_d         = y_q;
    mode_d      = mode_q;
    cont_d      = cont_q;
    stop_d      = stop_q;
    frame_start = 1'b0;
    stop_eff    = stop_q | stop;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          cont_d      = continuous;
          stop_d      = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (h_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = ST_VSYNC;
          end else if (HAS_HBLANK) begin
            state_d = ST_HBLANK;
            h_d     = h_q + LEN_X'(1);
          end else begin
            h_d = '0;
            y_d = y_q + LEN_Y'(1);
          end
        end else begin
          h_d = h_q + LEN_X'(1);
        end
      end
      ST_HBLANK: begin
        if (h_q == H_LAST) begin
          state_d = ST_ACTIVE;
          h_d     = '0;
          y_d     = y_q + LEN_Y'(1);
        end else begin
          h_d = h_q + LEN_X'(1);
        end
      end
      ST_VSYNC: begin
        if (HAS_VBLANK) begin
          state_d = ST_VBLANK;
          h_d     = '0;
          y_d     = Y_VB0;
        end else if (cont_q && !stop_eff) begin
          frame_start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VBLANK: begin
        // Blank lines continue the line count past the active area.
        if (h_q == H_LAST) begin
          if (y_q == Y_VB_LAST) begin
            if (cont_q && !stop_eff) frame_start = 1'b1;
            else                     state_d     = ST_IDLE;
          end else begin
            h_d = '0;
            y_d = y_q + LEN_Y'(1);
          end
        end else begin
          h_d = h_q + LEN_X'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      state_d = ST_ACTIVE;
      h_d     = '0;
      y_d     = '0;
      mode_d  = mode_e'(mode);
    end

    if ((state_q != ST_IDLE) && stop) stop_d = 1'b1;
    if (state_d == ST_IDLE)           stop_d = 1'b0;

    de_d        = (state_d == ST_ACTIVE);
    hsync_d     = (state_d == ST_HBLANK) && (h_d == X_BLANK0);
    vsync_d     = (state_d == ST_VSYNC);
    busy_d      = (state_d != ST_IDLE);
    frame_cnt_d = frame_cnt + FRAME_CNT_W'(vsync_d);
  end

  assign pixel_d = de_d ? pat_c : '0;

endmodule
